// File: rtl/riscv_irq_pkg.sv
// Shared definitions for the interrupt controller: FSM state encoding and
// register-port address map.
package riscv_irq_pkg;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_REQ     = 2'd1,
        IRQ_SERVICE = 2'd2
    } irq_state_e;

    localparam logic [1:0] ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] ADDR_PENDING = 2'd1;
    localparam logic [1:0] ADDR_MODE    = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

endpackage

// File: rtl/irq_priority_encoder.sv
// Combinational lowest-index-wins priority encoder over the masked request
// vector. The index is meaningful only while valid is high.
module irq_priority_encoder #(
    parameter int unsigned NUM_SRC = 8
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               valid,
    output logic [4:0]         idx
);

    assign valid = |req;

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = 5'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller feeding the core's single interrupt input: synchronises
// external requests, keeps ENABLE/PENDING/MODE registers, picks the
// lowest-index active source and handshakes it with the core (ack / done).
// One interrupt is tracked in service at a time; there is no nesting.
module irq_controller
    import riscv_irq_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 8,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter logic [31:0] VEC_STRIDE = 32'd4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    output logic [31:0]        cfg_rdata,
    output logic               interrupt,
    input  logic               irq_ack,
    input  logic               irq_done,
    output logic [4:0]         irq_id,
    output logic [31:0]        irq_vector
);

    logic [NUM_SRC-1:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [NUM_SRC-1:0] enable_q, enable_d, mode_q, mode_d, pending_q, pending_d;
    irq_state_e         state_q, state_d;
    logic               interrupt_q, interrupt_d;
    logic [4:0]         irq_id_q, irq_id_d;
    logic [31:0]        irq_vector_q, irq_vector_d;

    logic [NUM_SRC-1:0] rise, hw_clear, id_hit, active;
    logic               wr_enable, wr_pending, wr_mode, ack_take, latched_active;
    logic               enc_valid;
    logic [4:0]         enc_idx;
    logic               unused_wdata_bits;

    // Write data above NUM_SRC has no register behind it.
    assign unused_wdata_bits = ^cfg_wdata;

    assign wr_enable  = cfg_we && (cfg_addr == ADDR_ENABLE);
    assign wr_pending = cfg_we && (cfg_addr == ADDR_PENDING);
    assign wr_mode    = cfg_we && (cfg_addr == ADDR_MODE);
    assign ack_take   = (state_q == IRQ_REQ) && irq_ack;
    assign active     = pending_q & enable_q;

    // Per-source edge detect and pending update; a hardware set beats any clear.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        assign id_hit[gi]    = (irq_id_q == 5'(gi));
        assign rise[gi]      = sync2_q[gi] & ~prev_q[gi];
        assign hw_clear[gi]  = (wr_pending & cfg_wdata[gi]) | (ack_take & id_hit[gi]);
        assign pending_d[gi] = mode_q[gi] ? (rise[gi] | (pending_q[gi] & ~hw_clear[gi]))
                                          : sync2_q[gi];
    end

    // The source latched in irq_id is still asking for service.
    assign latched_active = |(active & id_hit);

    irq_priority_encoder #(
        .NUM_SRC (NUM_SRC)
    ) u_prio (
        .req   (active),
        .valid (enc_valid),
        .idx   (enc_idx)
    );

    // Synchroniser chain and software-written configuration registers.
    always_comb begin
        sync1_d  = irq_src;
        sync2_d  = sync1_q;
        prev_d   = sync2_q;
        enable_d = enable_q;
        mode_d   = mode_q;
        if (wr_enable) begin
            enable_d = cfg_wdata[NUM_SRC-1:0];
        end
        if (wr_mode) begin
            mode_d = cfg_wdata[NUM_SRC-1:0];
        end
    end

    // Next-state logic: ack beats withdraw while a request is outstanding.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IRQ_IDLE:    if (enc_valid) state_d = IRQ_REQ;
            IRQ_REQ: begin
                if (irq_ack) begin
                    state_d = IRQ_SERVICE;
                end else if (!latched_active) begin
                    state_d = IRQ_IDLE;
                end
            end
            IRQ_SERVICE: if (irq_done) state_d = IRQ_IDLE;
            default:     state_d = IRQ_IDLE;
        endcase
    end

    // Registered outputs: the winner is latched only on leaving IDLE, so a
    // higher-priority arrival during REQ does not change irq_id.
    always_comb begin
        interrupt_d  = interrupt_q;
        irq_id_d     = irq_id_q;
        irq_vector_d = irq_vector_q;
        case (state_q)
            IRQ_IDLE: begin
                interrupt_d = 1'b0;
                if (enc_valid) begin
                    interrupt_d  = 1'b1;
                    irq_id_d     = enc_idx;
                    irq_vector_d = VEC_BASE + 32'(enc_idx) * VEC_STRIDE;
                end
            end
            IRQ_REQ:     if (irq_ack || !latched_active) interrupt_d = 1'b0;
            IRQ_SERVICE: interrupt_d = 1'b0;
            default:     interrupt_d = 1'b0;
        endcase
    end

    // All state, cleared by the asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            prev_q       <= '0;
            enable_q     <= '0;
            mode_q       <= '0;
            pending_q    <= '0;
            state_q      <= IRQ_IDLE;
            interrupt_q  <= 1'b0;
            irq_id_q     <= '0;
            irq_vector_q <= VEC_BASE;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            enable_q     <= enable_d;
            mode_q       <= mode_d;
            pending_q    <= pending_d;
            state_q      <= state_d;
            interrupt_q  <= interrupt_d;
            irq_id_q     <= irq_id_d;
            irq_vector_q <= irq_vector_d;
        end
    end

    // Combinational register read; unimplemented bits read as zero.
    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            ADDR_ENABLE:  cfg_rdata[NUM_SRC-1:0] = enable_q;
            ADDR_PENDING: cfg_rdata[NUM_SRC-1:0] = pending_q;
            ADDR_MODE:    cfg_rdata[NUM_SRC-1:0] = mode_q;
            ADDR_STATUS:  cfg_rdata = {22'd0, state_q, 3'd0, irq_id_q};
            default:      cfg_rdata = '0;
        endcase
    end

    assign interrupt  = interrupt_q;
    assign irq_id     = irq_id_q;
    assign irq_vector = irq_vector_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: reset, edge latency, priority, withdraw,
// ack/withdraw and W1C/set collisions, in-service arrivals and mid-service reset.
module tb_irq_controller;
    import riscv_irq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  irq_src;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        interrupt;
    logic        irq_ack;
    logic        irq_done;
    logic [4:0]  irq_id;
    logic [31:0] irq_vector;

    int checks = 0;
    int errors = 0;

    irq_controller #(
        .NUM_SRC    (8),
        .VEC_BASE   (32'h0000_0100),
        .VEC_STRIDE (32'd4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_src    (irq_src),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata),
        .interrupt  (interrupt),
        .irq_ack    (irq_ack),
        .irq_done   (irq_done),
        .irq_id     (irq_id),
        .irq_vector (irq_vector)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        tick();
        cfg_we    = 1'b0;
        cfg_wdata = '0;
        $display("[%0t] cfg write addr=%0d data=%h", $time, a, d);
    endtask

    task automatic rd(input logic [1:0] a, input string tag, input logic [31:0] exp);
        cfg_addr = a;
        #1;
        $display("[%0t] cfg read  addr=%0d data=%h (%s)", $time, a, cfg_rdata, tag);
        chk(tag, cfg_rdata, exp);
    endtask

    task automatic do_ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        $display("[%0t] irq_ack pulse", $time);
    endtask

    task automatic do_done();
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        $display("[%0t] irq_done pulse", $time);
    endtask

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        irq_src   = '1;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        irq_ack   = 1'b0;
        irq_done  = 1'b0;
        rst       = 1'b0;

        // 1: reset state with every source asserted
        repeat (3) tick();
        chk("rst_interrupt", 32'(interrupt), 32'd0);
        chk("rst_vector", irq_vector, 32'h100);
        chk("rst_id", 32'(irq_id), 32'd0);
        rd(ADDR_ENABLE,  "rst_enable",  32'h0);
        rd(ADDR_PENDING, "rst_pending", 32'h0);
        rd(ADDR_MODE,    "rst_mode",    32'h0);
        rd(ADDR_STATUS,  "rst_status",  32'h0);
        irq_src = '0;
        tick();
        rst = 1'b1;
        repeat (3) tick();

        // 2: edge latency on source 2
        cfg_write(ADDR_ENABLE, 32'h04);
        cfg_write(ADDR_MODE,   32'h04);
        irq_src = 8'h04;
        tick();                      // edge k
        irq_src = 8'h00;
        tick();                      // k+1
        tick();                      // k+2
        chk("t2_int_k2", 32'(interrupt), 32'd0);
        rd(ADDR_PENDING, "t2_pend_k2", 32'h04);
        tick();                      // k+3
        chk("t2_int_k3", 32'(interrupt), 32'd1);
        chk("t2_id", 32'(irq_id), 32'd2);
        chk("t2_vector", irq_vector, 32'h108);
        rd(ADDR_STATUS, "t2_status_req", 32'h102);
        do_ack();
        chk("t2_int_ack", 32'(interrupt), 32'd0);
        rd(ADDR_PENDING, "t2_pend_ack", 32'h00);
        rd(ADDR_STATUS, "t2_status_svc", 32'h202);
        do_done();
        rd(ADDR_STATUS, "t2_status_done", 32'h002);

        // 3: priority between sources 5 and 1
        cfg_write(ADDR_ENABLE, 32'h22);
        cfg_write(ADDR_MODE,   32'h22);
        irq_src = 8'h22;
        tick();
        irq_src = 8'h00;
        repeat (3) tick();
        chk("t3_int", 32'(interrupt), 32'd1);
        chk("t3_id_first", 32'(irq_id), 32'd1);
        chk("t3_vec_first", irq_vector, 32'h104);
        do_ack();
        chk("t3_int_ack", 32'(interrupt), 32'd0);
        rd(ADDR_PENDING, "t3_pend_left", 32'h20);
        do_done();
        chk("t3_int_done", 32'(interrupt), 32'd0);
        tick();
        chk("t3_int_second", 32'(interrupt), 32'd1);
        chk("t3_id_second", 32'(irq_id), 32'd5);
        chk("t3_vec_second", irq_vector, 32'h114);
        do_ack();
        do_done();
        rd(ADDR_STATUS, "t3_status_end", 32'h005);

        // 4: level source withdrawn by clearing ENABLE before ack
        cfg_write(ADDR_MODE,   32'h00);
        cfg_write(ADDR_ENABLE, 32'h08);
        irq_src = 8'h08;
        repeat (4) tick();
        chk("t4_int", 32'(interrupt), 32'd1);
        chk("t4_id", 32'(irq_id), 32'd3);
        cfg_write(ADDR_ENABLE, 32'h00);
        tick();
        chk("t4_int_withdrawn", 32'(interrupt), 32'd0);
        rd(ADDR_STATUS, "t4_status_idle", 32'h003);
        do_ack();
        rd(ADDR_STATUS, "t4_ack_ignored", 32'h003);

        // 5a: ack arrives while the latched source is already disabled
        cfg_write(ADDR_ENABLE, 32'h08);
        tick();
        chk("t5_req", 32'(interrupt), 32'd1);
        cfg_write(ADDR_ENABLE, 32'h00);
        do_ack();
        chk("t5_int_ack", 32'(interrupt), 32'd0);
        rd(ADDR_STATUS, "t5_ack_wins", 32'h203);
        do_done();
        irq_src = 8'h00;
        repeat (3) tick();

        // 5b: W1C colliding with a fresh edge on source 0
        cfg_write(ADDR_MODE, 32'h01);
        irq_src = 8'h01;
        tick();
        irq_src = 8'h00;
        repeat (2) tick();
        rd(ADDR_PENDING, "t5_pend_set", 32'h01);
        cfg_write(ADDR_PENDING, 32'h01);
        rd(ADDR_PENDING, "t5_w1c", 32'h00);
        irq_src = 8'h01;
        tick();                      // edge k
        irq_src = 8'h00;
        tick();                      // k+1
        cfg_write(ADDR_PENDING, 32'h01);   // lands on k+2 with the set
        rd(ADDR_PENDING, "t5_set_wins", 32'h01);
        cfg_write(ADDR_PENDING, 32'h01);
        rd(ADDR_PENDING, "t5_w1c_again", 32'h00);

        // 6: arrival while in service, then reset mid-service
        cfg_write(ADDR_MODE,   32'h05);
        cfg_write(ADDR_ENABLE, 32'h04);
        irq_src = 8'h04;
        tick();
        irq_src = 8'h00;
        repeat (3) tick();
        chk("t6_int", 32'(interrupt), 32'd1);
        chk("t6_id", 32'(irq_id), 32'd2);
        do_ack();
        cfg_write(ADDR_ENABLE, 32'h05);
        irq_src = 8'h01;
        tick();
        irq_src = 8'h00;
        repeat (2) tick();
        rd(ADDR_PENDING, "t6_pend_in_svc", 32'h01);
        chk("t6_int_svc", 32'(interrupt), 32'd0);
        tick();
        chk("t6_int_hold", 32'(interrupt), 32'd0);
        do_done();
        chk("t6_int_at_idle", 32'(interrupt), 32'd0);
        rd(ADDR_STATUS, "t6_status_idle", 32'h002);
        tick();
        chk("t6_int_next", 32'(interrupt), 32'd1);
        chk("t6_id_next", 32'(irq_id), 32'd0);
        chk("t6_vec_next", irq_vector, 32'h100);
        do_ack();
        rd(ADDR_STATUS, "t6_status_svc", 32'h200);
        rst = 1'b0;
        #1;
        $display("[%0t] reset asserted in service", $time);
        rd(ADDR_STATUS, "t6_rst_status", 32'h000);
        chk("t6_rst_int", 32'(interrupt), 32'd0);
        rd(ADDR_PENDING, "t6_rst_pending", 32'h00);
        rd(ADDR_ENABLE, "t6_rst_enable", 32'h00);
        chk("t6_rst_vector", irq_vector, 32'h100);
        rst = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
